// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared mode encodings and pixel packing for the camera capture path
// Purpose: common types and helpers imported by cam_capture.
// Contents: cam_mode_e byte-format encodings, mode_norm, pack_rgb565/pack_grey/pack_raw.
package cam_pkg;

  localparam int CAM_DATA_W = 8;
  localparam int CAM_PIX_W  = 2 * CAM_DATA_W;

  typedef enum logic [1:0] {
    MODE_RGB565 = 2'd0,
    MODE_GREY   = 2'd1,
    MODE_RAW    = 2'd2,
    MODE_RSVD   = 2'd3
  } cam_mode_e;

  // The reserved encoding behaves exactly like RGB565, so it is folded at latch time.
  function automatic cam_mode_e mode_norm(input logic [1:0] m);
    return (m == 2'd3) ? MODE_RGB565 : cam_mode_e'(m);
  endfunction

  function automatic logic [CAM_PIX_W-1:0] pack_rgb565(input logic [CAM_DATA_W-1:0] b0,
                                                       input logic [CAM_DATA_W-1:0] b1);
    return {b0, b1};
  endfunction

  function automatic logic [CAM_PIX_W-1:0] pack_grey(input logic [CAM_DATA_W-1:0] y);
    return {y, y};
  endfunction

  function automatic logic [CAM_PIX_W-1:0] pack_raw(input logic [CAM_DATA_W-1:0] b);
    return {{CAM_DATA_W{1'b0}}, b};
  endfunction

endpackage

// File: rtl/cam_sync_edge.sv
// rtl/cam_sync_edge.sv - 2-flop synchronizer with registered rise/fall detect
// Purpose: bring one asynchronous camera pin into the CLK domain.
// Ports: clk, rst (async active-high), din (async pin),
//        lvl (synced level, aligned with the edge pulses), rise/fall (one-cycle pulses).
module cam_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic s3_q, s3_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  // s3 holds the previous synced value; the edge pulses are registered so that
  // they line up with s3 (the new level) in the same cycle.
  always_comb begin
    s1_d   = din;
    s2_d   = s1_q;
    s3_d   = s2_q;
    rise_d = s2_q & ~s3_q;
    fall_d = ~s2_q & s3_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      s3_q   <= s3_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign lvl  = s3_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/cam_capture.sv
// rtl/cam_capture.sv - camera byte capture, pixel assembly, decimation and pixel stream
// Purpose: sample the parallel camera bus, build pixels, emit them with x/y on a valid/ready stream.
// Ports: CLK/RST (async active-high); CamHsync/CamVsync/PCLK/CamData async camera pins;
//        Mode/Half latched at frame arming, CapEn sampled at arming, ErrClr clears sticky flags;
//        PixValid/PixReady/PixData/PixX/PixY/FrameStart/LineEnd pixel stream;
//        FrameDone pulse, Overrun/FmtErr sticky flags.
module cam_capture
  import cam_pkg::*;
#(
  parameter int DATA_W   = CAM_DATA_W,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int CNT_W    = 10
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                CamHsync,
  input  logic                CamVsync,
  input  logic                PCLK,
  input  logic [DATA_W-1:0]   CamData,
  input  logic [1:0]          Mode,
  input  logic                Half,
  input  logic                CapEn,
  input  logic                ErrClr,
  input  logic                PixReady,
  output logic                PixValid,
  output logic [2*DATA_W-1:0] PixData,
  output logic [CNT_W-1:0]    PixX,
  output logic [CNT_W-1:0]    PixY,
  output logic                FrameStart,
  output logic                LineEnd,
  output logic                FrameDone,
  output logic                Overrun,
  output logic                FmtErr
);

  localparam logic [CNT_W-1:0] H_FULL  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_HALF  = CNT_W'(H_ACTIVE / 2);
  localparam logic [CNT_W-1:0] V_FULL  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_HALF  = CNT_W'(V_ACTIVE / 2);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // ---------------- input synchronization ----------------
  logic pclk_lvl, pclk_rise, pclk_fall;
  logic hs_lvl, hs_rise, hs_fall;
  logic vs_lvl, vs_rise, vs_fall;
  logic unused_sync;

  cam_sync_edge u_sync_pclk (.clk(CLK), .rst(RST), .din(PCLK),
                             .lvl(pclk_lvl), .rise(pclk_rise), .fall(pclk_fall));
  cam_sync_edge u_sync_hs   (.clk(CLK), .rst(RST), .din(CamHsync),
                             .lvl(hs_lvl), .rise(hs_rise), .fall(hs_fall));
  cam_sync_edge u_sync_vs   (.clk(CLK), .rst(RST), .din(CamVsync),
                             .lvl(vs_lvl), .rise(vs_rise), .fall(vs_fall));

  assign unused_sync = pclk_lvl ^ pclk_fall ^ hs_rise ^ vs_lvl;

  // Data gets three stages so it lines up with the registered PCLK edge pulse.
  logic [DATA_W-1:0] dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d, dat_s3_q, dat_s3_d;

  always_comb begin
    dat_s1_d = CamData;
    dat_s2_d = dat_s1_q;
    dat_s3_d = dat_s2_q;
  end

  // ---------------- capture state ----------------
  logic                armed_q, armed_d;
  cam_mode_e           mode_q, mode_d;
  logic                half_q, half_d;
  logic                phase_q, phase_d;
  logic [DATA_W-1:0]   byte0_q, byte0_d;
  logic [CNT_W-1:0]    x_q, x_d;
  logic [CNT_W-1:0]    y_q, y_d;
  logic                rawx_odd_q, rawx_odd_d;
  logic                rawy_odd_q, rawy_odd_d;
  logic                line_bytes_q, line_bytes_d;
  logic                first_q, first_d;
  logic                last_loaded_q, last_loaded_d;
  logic                pix_valid_q, pix_valid_d;
  logic [2*DATA_W-1:0] pix_data_q, pix_data_d;
  logic [CNT_W-1:0]    pix_x_q, pix_x_d;
  logic [CNT_W-1:0]    pix_y_q, pix_y_d;
  logic                frame_start_q, frame_start_d;
  logic                line_end_q, line_end_d;
  logic                frame_done_q, frame_done_d;
  logic                overrun_q, overrun_d;
  logic                fmt_err_q, fmt_err_d;

  logic                accept, pix_done, loaded_now, line_end_ev;
  logic [2*DATA_W-1:0] pix_word;
  logic [CNT_W-1:0]    h_out, v_out;

  always_comb begin
    armed_d       = armed_q;
    mode_d        = mode_q;
    half_d        = half_q;
    phase_d       = phase_q;
    byte0_d       = byte0_q;
    x_d           = x_q;
    y_d           = y_q;
    rawx_odd_d    = rawx_odd_q;
    rawy_odd_d    = rawy_odd_q;
    line_bytes_d  = line_bytes_q;
    first_d       = first_q;
    last_loaded_d = last_loaded_q;
    pix_valid_d   = pix_valid_q;
    pix_data_d    = pix_data_q;
    pix_x_d       = pix_x_q;
    pix_y_d       = pix_y_q;
    frame_start_d = frame_start_q;
    line_end_d    = line_end_q;
    frame_done_d  = 1'b0;
    // Clear first; set events below override it in the same cycle.
    overrun_d     = overrun_q & ~ErrClr;
    fmt_err_d     = fmt_err_q & ~ErrClr;
    pix_done      = 1'b0;
    pix_word      = '0;
    loaded_now    = 1'b0;

    h_out  = half_q ? H_HALF : H_FULL;
    v_out  = half_q ? V_HALF : V_FULL;
    accept = pix_valid_q & PixReady;

    if (accept) begin
      pix_valid_d   = 1'b0;
      frame_start_d = 1'b0;
      line_end_d    = 1'b0;
      last_loaded_d = 1'b0;
    end

    // Byte assembly
    if (armed_q && pclk_rise && hs_lvl) begin
      line_bytes_d = 1'b1;
      case (mode_q)
        MODE_GREY: begin
          phase_d = ~phase_q;
          if (!phase_q) begin
            pix_done = 1'b1;
            pix_word = pack_grey(dat_s3_q);
          end
        end
        MODE_RAW: begin
          pix_done = 1'b1;
          pix_word = pack_raw(dat_s3_q);
        end
        default: begin
          if (!phase_q) begin
            byte0_d = dat_s3_q;
            phase_d = 1'b1;
          end else begin
            pix_done = 1'b1;
            pix_word = pack_rgb565(byte0_q, dat_s3_q);
            phase_d  = 1'b0;
          end
        end
      endcase
    end

    // Pixel placement: decimation, range check, load or drop
    if (pix_done) begin
      rawx_odd_d = ~rawx_odd_q;
      if (!half_q || (!rawx_odd_q && !rawy_odd_q)) begin
        last_loaded_d = 1'b0;
        if (x_q >= h_out) begin
          fmt_err_d = 1'b1;
        end else if (!pix_valid_q || accept) begin
          pix_valid_d   = 1'b1;
          pix_data_d    = pix_word;
          pix_x_d       = x_q;
          pix_y_d       = y_q;
          frame_start_d = first_q;
          line_end_d    = 1'b0;
          first_d       = 1'b0;
          last_loaded_d = 1'b1;
          loaded_now    = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
        x_d = sat_inc(x_q);
      end
    end

    // Line end: HREF fall, or Vsync rising while HREF is still high.
    line_end_ev = armed_q & (hs_fall | (vs_rise & hs_lvl));
    if (line_end_ev) begin
      if (x_d != '0) begin
        if (loaded_now || (pix_valid_q && !accept && last_loaded_q)) begin
          line_end_d = 1'b1;
        end else if (!pix_valid_q || accept) begin
          // Marker pixel: zero data one past the last x, carries LineEnd only.
          pix_valid_d   = 1'b1;
          pix_data_d    = '0;
          pix_x_d       = x_d;
          pix_y_d       = y_q;
          frame_start_d = 1'b0;
          line_end_d    = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
        if (x_d != h_out) fmt_err_d = 1'b1;
        y_d = sat_inc(y_q);
      end
      if (line_bytes_d) rawy_odd_d = ~rawy_odd_q;
      x_d           = '0;
      phase_d       = 1'b0;
      rawx_odd_d    = 1'b0;
      line_bytes_d  = 1'b0;
      last_loaded_d = 1'b0;
    end

    if (armed_q && vs_rise) begin
      frame_done_d = 1'b1;
      if (y_d != v_out) fmt_err_d = 1'b1;
      armed_d = 1'b0;
    end

    if (vs_fall) begin
      armed_d      = CapEn;
      mode_d       = mode_norm(Mode);
      half_d       = Half;
      x_d          = '0;
      y_d          = '0;
      phase_d      = 1'b0;
      rawx_odd_d   = 1'b0;
      rawy_odd_d   = 1'b0;
      line_bytes_d = 1'b0;
      first_d      = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dat_s1_q      <= '0;
      dat_s2_q      <= '0;
      dat_s3_q      <= '0;
      armed_q       <= 1'b0;
      mode_q        <= MODE_RGB565;
      half_q        <= 1'b0;
      phase_q       <= 1'b0;
      byte0_q       <= '0;
      x_q           <= '0;
      y_q           <= '0;
      rawx_odd_q    <= 1'b0;
      rawy_odd_q    <= 1'b0;
      line_bytes_q  <= 1'b0;
      first_q       <= 1'b0;
      last_loaded_q <= 1'b0;
      pix_valid_q   <= 1'b0;
      pix_data_q    <= '0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      frame_start_q <= 1'b0;
      line_end_q    <= 1'b0;
      frame_done_q  <= 1'b0;
      overrun_q     <= 1'b0;
      fmt_err_q     <= 1'b0;
    end else begin
      dat_s1_q      <= dat_s1_d;
      dat_s2_q      <= dat_s2_d;
      dat_s3_q      <= dat_s3_d;
      armed_q       <= armed_d;
      mode_q        <= mode_d;
      half_q        <= half_d;
      phase_q       <= phase_d;
      byte0_q       <= byte0_d;
      x_q           <= x_d;
      y_q           <= y_d;
      rawx_odd_q    <= rawx_odd_d;
      rawy_odd_q    <= rawy_odd_d;
      line_bytes_q  <= line_bytes_d;
      first_q       <= first_d;
      last_loaded_q <= last_loaded_d;
      pix_valid_q   <= pix_valid_d;
      pix_data_q    <= pix_data_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      frame_start_q <= frame_start_d;
      line_end_q    <= line_end_d;
      frame_done_q  <= frame_done_d;
      overrun_q     <= overrun_d;
      fmt_err_q     <= fmt_err_d;
    end
  end

  assign PixValid   = pix_valid_q;
  assign PixData    = pix_data_q;
  assign PixX       = pix_x_q;
  assign PixY       = pix_y_q;
  assign FrameStart = frame_start_q;
  assign LineEnd    = line_end_q;
  assign FrameDone  = frame_done_q;
  assign Overrun    = overrun_q;
  assign FmtErr     = fmt_err_q;

endmodule
